// File: rtl/threshold_event_detector_if.sv
// Bundle between the threshold comparator stage and the event detector.
// enb is a one-way sample strobe with no ready/backpressure: in_above is taken on every clk edge where enb=1.
interface threshold_event_detector_if #(
  parameter int CNT_W = 16,
  parameter int DUR_W = 16
);
  logic             enb;
  logic             in_above;
  logic             detect;
  logic             event_start;
  logic             event_end;
  logic [CNT_W-1:0] event_count;
  logic [DUR_W-1:0] last_duration;
  logic             dur_overflow;
  logic [1:0]       dbg_state;

  modport master (
    output enb, in_above,
    input  detect, event_start, event_end, event_count, last_duration, dur_overflow, dbg_state
  );

  modport slave (
    input  enb, in_above,
    output detect, event_start, event_end, event_count, last_duration, dur_overflow, dbg_state
  );
endinterface

// File: rtl/threshold_event_detector.sv
// Debounced, hysteretic event detector for a 1-bit comparator stream with
// start/end pulses, a saturating event count and last-event duration.
module threshold_event_detector #(
  parameter int ON_COUNT  = 3,
  parameter int OFF_COUNT = 2,
  parameter int CNT_W     = 16,
  parameter int DUR_W     = 16
) (
  input  logic clk,
  input  logic reset,
  threshold_event_detector_if.slave bus
);
  typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, RELEASE} state_t;

  localparam logic [8:0]       ON_L     = 9'(ON_COUNT);
  localparam logic [8:0]       OFF_L    = 9'(OFF_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  state_t           state, state_nxt;
  logic [7:0]       run, run_nxt;
  logic [DUR_W-1:0] dur, dur_nxt;
  logic             ovf, ovf_nxt;
  logic             det, det_nxt;
  logic             start_p, start_nxt;
  logic             end_p, end_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DUR_W-1:0] last, last_nxt;
  logic             lovf, lovf_nxt;

  logic [8:0]       run_p1;
  logic [DUR_W-1:0] dur_inc;
  logic             ovf_inc;
  logic             do_start, do_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      run     <= '0;
      dur     <= '0;
      ovf     <= 1'b0;
      det     <= 1'b0;
      start_p <= 1'b0;
      end_p   <= 1'b0;
      cnt     <= '0;
      last    <= '0;
      lovf    <= 1'b0;
    end else begin
      state   <= state_nxt;
      run     <= run_nxt;
      dur     <= dur_nxt;
      ovf     <= ovf_nxt;
      det     <= det_nxt;
      start_p <= start_nxt;
      end_p   <= end_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      lovf    <= lovf_nxt;
    end
  end

  // dur_inc/ovf_inc already include the sample being taken on this edge.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    dur_nxt   = dur;
    ovf_nxt   = ovf;
    det_nxt   = det;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    cnt_nxt   = cnt;
    last_nxt  = last;
    lovf_nxt  = lovf;
    do_start  = 1'b0;
    do_end    = 1'b0;
    run_p1    = {1'b0, run} + 9'd1;
    dur_inc   = (dur == DUR_MAX) ? dur : dur + 1'b1;
    ovf_inc   = ovf | (dur_inc == DUR_MAX);

    if (bus.enb) begin
      case (state)
        IDLE: begin
          if (bus.in_above) begin
            if (ON_COUNT == 1) begin
              do_start = 1'b1;
            end else begin
              state_nxt = QUALIFY;
              run_nxt   = 8'd1;
            end
          end
        end
        QUALIFY: begin
          if (!bus.in_above) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else if (run_p1 == ON_L) begin
            do_start = 1'b1;
          end else begin
            run_nxt = run_p1[7:0];
          end
        end
        ACTIVE: begin
          dur_nxt = dur_inc;
          ovf_nxt = ovf_inc;
          if (!bus.in_above) begin
            if (OFF_COUNT == 1) begin
              do_end = 1'b1;
            end else begin
              state_nxt = RELEASE;
              run_nxt   = 8'd1;
            end
          end
        end
        RELEASE: begin
          dur_nxt = dur_inc;
          ovf_nxt = ovf_inc;
          if (bus.in_above) begin
            state_nxt = ACTIVE;
            run_nxt   = '0;
          end else if (run_p1 == OFF_L) begin
            do_end = 1'b1;
          end else begin
            run_nxt = run_p1[7:0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (do_start) begin
      state_nxt = ACTIVE;
      det_nxt   = 1'b1;
      start_nxt = 1'b1;
      cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      dur_nxt   = '0;
      run_nxt   = '0;
      ovf_nxt   = 1'b0;
    end

    if (do_end) begin
      state_nxt = IDLE;
      det_nxt   = 1'b0;
      end_nxt   = 1'b1;
      last_nxt  = dur_inc;
      lovf_nxt  = ovf_inc;
      run_nxt   = '0;
    end
  end

  assign bus.detect        = det;
  assign bus.event_start   = start_p;
  assign bus.event_end     = end_p;
  assign bus.event_count   = cnt;
  assign bus.last_duration = last;
  assign bus.dur_overflow  = lovf;
  assign bus.dbg_state     = state;
endmodule
